// File: rtl/reg_file_wb_if.sv
// Write-back / register-read bundle between the pipeline and reg_file_wb.
// master = pipeline side, slave = register file side.
interface reg_file_wb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] IN_ALU;
  logic [DATA_W-1:0] IN_MEM;
  logic              WB_SEL;
  logic              WRITE;
  logic [ADDR_W-1:0] INADDRESS;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic              BUSYWAIT;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              WB_PENDING;

  modport master (
    output IN_ALU, IN_MEM, WB_SEL, WRITE,
    output INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
    output BUSYWAIT,
    input  OUT1, OUT2, WB_PENDING
  );

  modport slave (
    input  IN_ALU, IN_MEM, WB_SEL, WRITE,
    input  INADDRESS, OUT1ADDRESS, OUT2ADDRESS,
    input  BUSYWAIT,
    output OUT1, OUT2, WB_PENDING
  );
endinterface

// File: rtl/reg_file_wb.sv
// Register file with a write-back FSM that holds memory loads across stalls.
// Optional REGFILE_BYPASS_EN forwards the committing write to the read ports.
module reg_file_wb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  reg_file_wb_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    we          = 1'b0;
    waddr       = bus.INADDRESS;
    wdata       = bus.WB_SEL ? bus.IN_MEM : bus.IN_ALU;
    unique case (state_q)
      IDLE: begin
        if (bus.WRITE) begin
          if (!bus.BUSYWAIT) begin
            we = 1'b1;
          end else if (bus.WB_SEL) begin
            pend_addr_d = bus.INADDRESS;
            state_d     = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        waddr = pend_addr_q;
        wdata = bus.IN_MEM;
        if (!bus.BUSYWAIT) begin
          we      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      regs_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.WB_PENDING = (state_q == WAIT_MEM);

`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by RESET so the ports read zero while it is held.
  logic byp1, byp2;
  assign byp1 = we && !RESET && (waddr == bus.OUT1ADDRESS);
  assign byp2 = we && !RESET && (waddr == bus.OUT2ADDRESS);
  assign bus.OUT1 = byp1 ? wdata : regs_q[bus.OUT1ADDRESS];
  assign bus.OUT2 = byp2 ? wdata : regs_q[bus.OUT2ADDRESS];
`else
  assign bus.OUT1 = regs_q[bus.OUT1ADDRESS];
  assign bus.OUT2 = regs_q[bus.OUT2ADDRESS];
`endif
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: stimulus pushes expected read-port values,
// a negedge monitor pops and compares them.
module tb_reg_file_wb;
  logic CLK = 1'b0;
  logic RESET;

  reg_file_wb_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  reg_file_wb #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [7:0] o1;
    logic [7:0] o2;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   step_no = 0;

  // Reference: plain array of registers plus the pending target (-1 = none).
  logic [7:0] mdl [8];
  int         pend_reg = -1;

  task automatic step(input bit rst, input bit wr, input bit sel,
                      input logic [2:0] ia, input logic [7:0] alu,
                      input logic [7:0] mem, input bit busy,
                      input logic [2:0] a1, input logic [2:0] a2);
    exp_t       e;
    bit         w;
    logic [2:0] wa;
    logic [7:0] wd;
    @(posedge CLK);
    #1;
    RESET           = rst;
    bus.WRITE       = wr;
    bus.WB_SEL      = sel;
    bus.INADDRESS   = ia;
    bus.IN_ALU      = alu;
    bus.IN_MEM      = mem;
    bus.BUSYWAIT    = busy;
    bus.OUT1ADDRESS = a1;
    bus.OUT2ADDRESS = a2;
    w  = 1'b0;
    wa = '0;
    wd = '0;
    if (!rst) begin
      if (pend_reg >= 0) begin
        if (!busy) begin
          w  = 1'b1;
          wa = 3'(pend_reg);
          wd = mem;
        end
      end else if (wr && !busy) begin
        w  = 1'b1;
        wa = ia;
        wd = sel ? mem : alu;
      end
    end
    e.id = step_no;
    e.o1 = rst ? 8'h00 : mdl[a1];
    e.o2 = rst ? 8'h00 : mdl[a2];
`ifdef REGFILE_BYPASS_EN
    if (w && wa == a1) e.o1 = wd;
    if (w && wa == a2) e.o2 = wd;
`endif
    e.p = !rst && (pend_reg >= 0);
    q.push_back(e);
    step_no++;
    if (rst) begin
      foreach (mdl[i]) mdl[i] = 8'h00;
      pend_reg = -1;
    end else begin
      if (w) mdl[wa] = wd;
      if (pend_reg >= 0) begin
        if (!busy) pend_reg = -1;
      end else if (wr && busy && sel) begin
        pend_reg = int'(ia);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        compared++;
        if (bus.OUT1 !== e.o1) begin
          mismatched++;
          $display("FAIL out1 step=%0d got=%h exp=%h", e.id, bus.OUT1, e.o1);
        end
        compared++;
        if (bus.OUT2 !== e.o2) begin
          mismatched++;
          $display("FAIL out2 step=%0d got=%h exp=%h", e.id, bus.OUT2, e.o2);
        end
        compared++;
        if (bus.WB_PENDING !== e.p) begin
          mismatched++;
          $display("FAIL wb_pending step=%0d got=%b exp=%b",
                   e.id, bus.WB_PENDING, e.p);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] r;
    int         guard;
    RESET = 1'b1;
    bus.WRITE = 0; bus.WB_SEL = 0; bus.INADDRESS = 0;
    bus.IN_ALU = 0; bus.IN_MEM = 0; bus.BUSYWAIT = 0;
    bus.OUT1ADDRESS = 0; bus.OUT2ADDRESS = 0;
    foreach (mdl[i]) mdl[i] = 8'h00;
    for (int a = 0; a < 8; a++) step(1, 1, 1, 3'(a), 8'hFF, 8'hEE, 0, 3'(a), 3'(7 - a));
    // Fill every register, including reg0.
    for (int a = 0; a < 8; a++) step(0, 1, 0, 3'(a), 8'(8'h10 + a), 8'h00, 0, 3'(a), 0);
    step(0, 1, 0, 3, 8'h2A, 8'h00, 0, 3, 3);
    step(0, 0, 0, 0, 8'h00, 8'h00, 0, 3, 0);
    step(0, 1, 1, 5, 8'h00, 8'h33, 1, 5, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'h55, 8'h44, 1, 5, 1);
    step(0, 1, 0, 1, 8'h55, 8'h7F, 0, 5, 1);
    step(0, 0, 0, 0, 8'h00, 8'h00, 0, 5, 1);
    step(0, 1, 0, 2, 8'h11, 8'h00, 1, 2, 2);
    step(0, 0, 0, 0, 8'h00, 8'h00, 0, 2, 6);
    step(0, 1, 1, 6, 8'h00, 8'h00, 1, 6, 6);
    step(0, 0, 0, 0, 8'h00, 8'h00, 1, 6, 6);
    step(1, 0, 0, 0, 8'h00, 8'hAA, 1, 6, 6);
    step(0, 0, 0, 0, 8'h00, 8'hAA, 0, 6, 6);
    step(0, 0, 0, 0, 8'h00, 8'hAA, 0, 6, 6);
    step(0, 1, 0, 4, 8'h20, 8'h00, 0, 4, 4);
    step(0, 1, 0, 4, 8'h09, 8'h00, 0, 4, 4);
    step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 4);
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      step(($urandom_range(0, 49) == 0), r[0] | r[1], r[2],
           3'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom));
    end
    step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge CLK);
      guard++;
    end
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
